// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path.
// Contents: opcode constants, FSM state encoding, ALU operation codes,
// ALU B / PC source select encodings (also used by the datapath muxes),
// and the packed control-word struct produced by the state decoder.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALU_WB  = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bus between the multi-cycle control FSM and the datapath.
// master: FSM side (consumes opcode/mem_ready, drives every select/enable).
// slave : datapath side (drives opcode/mem_ready, consumes the controls).
interface mc_control_fsm_if #(
  parameter int CNT_W = 32
);
  import mips_pkg::*;

  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic             illegal_op;
  logic             instr_done;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, instr_done, instr_count
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, instr_done, instr_count
  );

endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> control-word decode (Moore outputs).
// Ports: state (current FSM state), mem_ready (memory handshake, only
// affects FETCH and MEM_WR outputs), ctrl (full control word).
// Anything not set in a state stays 0; unknown encodings decode to all 0.
module mc_ctrl_decode
  import mips_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC+4 only commit once the fetch actually returns.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Branch target precompute: PC + (imm << 2).
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADR, S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALU_WB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control unit (lw, sw, R-type, beq, j, addi).
// Ports: clk, rst_n (synchronous, active low), bus (master side of
// mc_control_fsm_if: opcode/mem_ready in; datapath selects, enables,
// illegal_op, instr_done and instr_count out).
// Holds the state register, next-state logic, sticky illegal_op flag and
// the retired-instruction counter; output decode lives in mc_ctrl_decode.
module mc_control_fsm
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  mc_control_fsm_if.master   bus
);

  state_t           state;
  state_t           state_nxt;
  ctrl_t            ctrl;
  ctrl_t            ctrl_g;
  logic             illegal_q;
  logic             illegal_set;
  logic [CNT_W-1:0] cnt_q;

  mc_ctrl_decode u_decode (
    .state     (state),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state <= state_nxt;
      if (illegal_set)
        illegal_q <= 1'b1;
      if (ctrl.instr_done)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt   = S_FETCH;
    illegal_set = 1'b0;
    unique case (state)
      S_FETCH:   state_nxt = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (bus.opcode)
          OP_LW, OP_SW: state_nxt = S_MEM_ADR;
          OP_RTYPE:     state_nxt = S_EXECUTE;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          OP_ADDI:      state_nxt = S_ADDI_EX;
          default: begin
            state_nxt   = S_FETCH;
            illegal_set = 1'b1;
          end
        endcase
      end
      S_MEM_ADR: begin
        if (bus.opcode == OP_LW)
          state_nxt = S_MEM_RD;
        else if (bus.opcode == OP_SW)
          state_nxt = S_MEM_WR;
        else
          state_nxt = S_FETCH;
      end
      S_MEM_RD:  state_nxt = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:  state_nxt = bus.mem_ready ? S_FETCH : S_MEM_WR;
      S_EXECUTE: state_nxt = S_ALU_WB;
      S_ADDI_EX: state_nxt = S_ADDI_WB;
      default:   state_nxt = S_FETCH;
    endcase
  end

  // While reset is held every output is forced low, so a reset that lands
  // mid-instruction cannot leak a memory, register-file or PC write.
  assign ctrl_g = rst_n ? ctrl : '0;

  assign bus.pc_write      = ctrl_g.pc_write;
  assign bus.pc_write_cond = ctrl_g.pc_write_cond;
  assign bus.iord          = ctrl_g.iord;
  assign bus.mem_read      = ctrl_g.mem_read;
  assign bus.mem_write     = ctrl_g.mem_write;
  assign bus.ir_write      = ctrl_g.ir_write;
  assign bus.mem_to_reg    = ctrl_g.mem_to_reg;
  assign bus.reg_dst       = ctrl_g.reg_dst;
  assign bus.reg_write     = ctrl_g.reg_write;
  assign bus.alu_src_a     = ctrl_g.alu_src_a;
  assign bus.alu_src_b     = ctrl_g.alu_src_b;
  assign bus.alu_op        = ctrl_g.alu_op;
  assign bus.pc_source     = ctrl_g.pc_source;
  assign bus.instr_done    = ctrl_g.instr_done;
  assign bus.illegal_op    = rst_n & illegal_q;
  assign bus.instr_count   = rst_n ? cnt_q : '0;

endmodule
